ysyx_23060025_mem_arbiter: RTL and testbench
============================================

# ysyx_23060025_mem_arbiter

Two-master, one-slave arbiter that shares the single memory port (icache/SRAM side) between the IFU instruction-fetch port and the LSU load/store port. It sits between the IFU/LSU and the memory interconnect. It grants one master at a time, latches that master's request attributes for the whole transaction, and routes the completion back only to the granted master.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width

Ports:
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- ifu_psel_i  in  1  IFU read request
- ifu_paddr_i  in  ADDR_WIDTH  IFU fetch address
- ifu_pready_o  out  1  IFU completion strobe
- ifu_prdata_o  out  DATA_WIDTH  IFU read data
- lsu_psel_i  in  1  LSU request
- lsu_pwrite_i  in  1  1 = write, 0 = read
- lsu_paddr_i  in  ADDR_WIDTH  LSU address
- lsu_pwdata_i  in  DATA_WIDTH  LSU write data
- lsu_pstrb_i  in  DATA_WIDTH/8  LSU byte strobes
- lsu_pready_o  out  1  LSU completion strobe
- lsu_prdata_o  out  DATA_WIDTH  LSU read data
- mem_psel_o  out  1  downstream request
- mem_pwrite_o  out  1  downstream write flag
- mem_paddr_o  out  ADDR_WIDTH  downstream address
- mem_pwdata_o  out  DATA_WIDTH  downstream write data
- mem_pstrb_o  out  DATA_WIDTH/8  downstream strobes
- mem_pready_i  in  1  downstream completion
- mem_prdata_i  in  DATA_WIDTH  downstream read data

## Operation
- States: IDLE, GNT_IFU, GNT_LSU.
- In IDLE, sample ifu_psel_i and lsu_psel_i:
  - Only one high: move to that master's GNT state.
  - Both high: apply the priority rule in Configuration.
  - Neither high: stay in IDLE.
- On the IDLE→GNT edge, latch addr/pwrite/pwdata/pstrb into registers. IFU grants latch pwrite=0, pstrb=0, pwdata=0.
- In a GNT state:
  - mem_psel_o=1; mem_p* driven from the latched registers.
  - Requester psel is ignored after the grant, so a master may drop psel in its completion cycle.
- Completion: mem_pready_i=1 in a GNT state.
  - Granted master's pready_o=1 in the same cycle (combinational).
  - Granted master's prdata_o = mem_prdata_i.
  - Next state is IDLE.
- The non-granted master's pready_o is always 0. prdata_o outputs are passthrough of mem_prdata_i and are valid only when that master's pready_o=1.
- mem_pready_i in IDLE is ignored and nothing is forwarded.

## Timing
Reset values (reset asserted):
- State = IDLE.
- Latched address/data/strobe/pwrite registers = 0.
- mem_psel_o=0, ifu_pready_o=0, lsu_pready_o=0.
- Round-robin last-grant register = LSU.

Latency:
- Request seen in IDLE at cycle N → mem_psel_o=1 with latched address from cycle N+1.
- Downstream pready at cycle M → master pready at M. IDLE at M+1. Earliest next mem_psel_o at M+2, giving one idle bubble between transactions.
- Zero-wait slave (pready in the first GNT cycle) → 2-cycle request-to-response.

Boundary conditions:
- Master deasserts psel before its grant (while still in IDLE): request is dropped, no grant.
- Changes to requester address/data during GNT have no effect on mem_p*.
- Reset mid-transaction: IDLE next cycle and mem_psel_o=0. An outstanding response is discarded; the downstream slave is reset by the same reset.
- A master whose psel is held continuously is re-granted only through IDLE.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the master not recorded as last granted. The last-grant register updates on every IDLE→GNT edge.
- Undefined: fixed priority, LSU wins every tie. No last-grant register is built.

## Test plan
- IFU only, psel with addr 0x80000000; slave pready after 3 wait cycles with data 0x00000413 → mem_paddr_o=0x80000000 with mem_pwrite_o=0; ifu_pready_o=1 and ifu_prdata_o=0x00000413 in the same cycle; lsu_pready_o stays 0.
- LSU write: addr 0xa00003f8, wdata 0x41, pstrb 0x1; zero-wait slave → mem_psel_o at N+1 with mem_pwrite_o=1 and mem_pstrb_o=0x1; lsu_pready_o at N+1; IDLE at N+2.
- Both request in the same cycle, fixed priority (macro undefined) → LSU granted first, IFU granted at LSU-completion+2.
- Both request continuously for 4 transactions with ARB_ROUND_ROBIN_EN → grant order IFU, LSU, IFU, LSU.
- IFU changes ifu_paddr_i 0x80000000→0x80000004 mid-grant and drops psel in the pready cycle → mem_paddr_o stays 0x80000000 throughout; exactly one ifu_pready_o pulse.
- Reset asserted during GNT_LSU with a pending slave → mem_psel_o=0 next cycle; a late mem_pready_i=1 in IDLE produces no pready on either master.

Source files
------------

// File: rtl/ysyx_23060025_mem_arbiter.sv
// Shares one memory port between the IFU fetch port and the LSU load/store port, one transaction at a time.
// Tie-break: define ARB_ROUND_ROBIN_EN for round-robin; the default build gives the LSU fixed priority.
module ysyx_23060025_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ifu_psel_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_paddr_i,
  output logic                    ifu_pready_o,
  output logic [DATA_WIDTH-1:0]   ifu_prdata_o,
  input  logic                    lsu_psel_i,
  input  logic                    lsu_pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_paddr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_pstrb_i,
  output logic                    lsu_pready_o,
  output logic [DATA_WIDTH-1:0]   lsu_prdata_o,
  output logic                    mem_psel_o,
  output logic                    mem_pwrite_o,
  output logic [ADDR_WIDTH-1:0]   mem_paddr_o,
  output logic [DATA_WIDTH-1:0]   mem_pwdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_pstrb_o,
  input  logic                    mem_pready_i,
  input  logic [DATA_WIDTH-1:0]   mem_prdata_i
);

  typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;

  state_t state;
  logic   pick_lsu;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won the previous grant; starts at LSU so the first tie goes to the IFU.
  logic last_lsu;

  always_comb begin
    pick_lsu = lsu_psel_i & (~ifu_psel_i | ~last_lsu);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_lsu <= 1'b1;
    end else if (state == IDLE && (ifu_psel_i || lsu_psel_i)) begin
      last_lsu <= pick_lsu;
    end
  end
`else
  assign pick_lsu = lsu_psel_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mem_psel_o   <= 1'b0;
      mem_pwrite_o <= 1'b0;
      mem_paddr_o  <= '0;
      mem_pwdata_o <= '0;
      mem_pstrb_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ifu_psel_i || lsu_psel_i) begin
            mem_psel_o <= 1'b1;
            if (pick_lsu) begin
              state        <= GNT_LSU;
              mem_pwrite_o <= lsu_pwrite_i;
              mem_paddr_o  <= lsu_paddr_i;
              mem_pwdata_o <= lsu_pwdata_i;
              mem_pstrb_o  <= lsu_pstrb_i;
            end else begin
              state        <= GNT_IFU;
              mem_pwrite_o <= 1'b0;
              mem_paddr_o  <= ifu_paddr_i;
              mem_pwdata_o <= '0;
              mem_pstrb_o  <= '0;
            end
          end
        end
        // Requester psel is ignored here; only the slave's completion releases the grant.
        GNT_IFU, GNT_LSU: begin
          if (mem_pready_i) begin
            state      <= IDLE;
            mem_psel_o <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mem_psel_o <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally, and only to the granted master.
  assign ifu_pready_o = (state == GNT_IFU) && mem_pready_i;
  assign lsu_pready_o = (state == GNT_LSU) && mem_pready_i;
  assign ifu_prdata_o = mem_prdata_i;
  assign lsu_prdata_o = mem_prdata_i;

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Self-checking bench for ysyx_23060025_mem_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the arbitration rules.
module tb_ysyx_23060025_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_psel_i = 1'b0;
  logic [31:0] ifu_paddr_i = '0;
  logic        ifu_pready_o;
  logic [31:0] ifu_prdata_o;
  logic        lsu_psel_i = 1'b0;
  logic        lsu_pwrite_i = 1'b0;
  logic [31:0] lsu_paddr_i = '0;
  logic [31:0] lsu_pwdata_i = '0;
  logic [3:0]  lsu_pstrb_i = '0;
  logic        lsu_pready_o;
  logic [31:0] lsu_prdata_o;
  logic        mem_psel_o;
  logic        mem_pwrite_o;
  logic [31:0] mem_paddr_o;
  logic [31:0] mem_pwdata_o;
  logic [3:0]  mem_pstrb_o;
  logic        mem_pready_i = 1'b0;
  logic [31:0] mem_prdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;
  int ifu_pulses = 0;

  always #5 clock = ~clock;

  ysyx_23060025_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .ifu_psel_i   (ifu_psel_i),
    .ifu_paddr_i  (ifu_paddr_i),
    .ifu_pready_o (ifu_pready_o),
    .ifu_prdata_o (ifu_prdata_o),
    .lsu_psel_i   (lsu_psel_i),
    .lsu_pwrite_i (lsu_pwrite_i),
    .lsu_paddr_i  (lsu_paddr_i),
    .lsu_pwdata_i (lsu_pwdata_i),
    .lsu_pstrb_i  (lsu_pstrb_i),
    .lsu_pready_o (lsu_pready_o),
    .lsu_prdata_o (lsu_prdata_o),
    .mem_psel_o   (mem_psel_o),
    .mem_pwrite_o (mem_pwrite_o),
    .mem_paddr_o  (mem_paddr_o),
    .mem_pwdata_o (mem_pwdata_o),
    .mem_pstrb_o  (mem_pstrb_o),
    .mem_pready_i (mem_pready_i),
    .mem_prdata_i (mem_prdata_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level model: at most one transaction in flight, described by who owns it and its attributes.
  typedef struct {
    bit          busy;
    bit          is_lsu;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  txn_t cur = '{busy: 1'b0, is_lsu: 1'b0, write: 1'b0, addr: '0, wdata: '0, strb: '0};
  bit   last_was_lsu = 1'b1;
  bit   grants[$];

  always @(negedge clock) begin
    bit ifu_done, lsu_done, take_lsu;
    ifu_done = cur.busy && !cur.is_lsu && mem_pready_i;
    lsu_done = cur.busy &&  cur.is_lsu && mem_pready_i;
    check("m_psel", mem_psel_o, cur.busy);
    check("m_ifu_rdy", ifu_pready_o, ifu_done);
    check("m_lsu_rdy", lsu_pready_o, lsu_done);
    if (cur.busy) begin
      check("m_paddr", mem_paddr_o, cur.addr);
      check("m_pwrite", mem_pwrite_o, cur.write);
      check("m_pwdata", mem_pwdata_o, cur.wdata);
      check("m_pstrb", mem_pstrb_o, cur.strb);
    end
    if (ifu_done) check("m_ifu_rdata", ifu_prdata_o, mem_prdata_i);
    if (lsu_done) check("m_lsu_rdata", lsu_prdata_o, mem_prdata_i);
    if (ifu_pready_o) ifu_pulses++;

    // Advance to what the next rising edge must produce.
    if (reset) begin
      cur.busy = 1'b0;
      last_was_lsu = 1'b1;
    end else if (cur.busy) begin
      if (mem_pready_i) cur.busy = 1'b0;
    end else if (ifu_psel_i || lsu_psel_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      take_lsu = lsu_psel_i && (!ifu_psel_i || !last_was_lsu);
`else
      take_lsu = lsu_psel_i;
`endif
      last_was_lsu = take_lsu;
      grants.push_back(take_lsu);
      cur.busy   = 1'b1;
      cur.is_lsu = take_lsu;
      cur.write  = take_lsu ? lsu_pwrite_i : 1'b0;
      cur.addr   = take_lsu ? lsu_paddr_i  : ifu_paddr_i;
      cur.wdata  = take_lsu ? lsu_pwdata_i : 32'h0;
      cur.strb   = take_lsu ? lsu_pstrb_i  : 4'h0;
    end
  end

  initial begin
    int p0;
    logic [31:0] seen[$];
    cyc();
    cyc();
    @(negedge clock);
    check("rst_psel", mem_psel_o, 1'b0);
    check("rst_paddr", mem_paddr_o, 32'h0);
    check("rst_ifu_rdy", ifu_pready_o, 1'b0);
    check("rst_lsu_rdy", lsu_pready_o, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();

    // IFU fetch with a three-wait-state slave.
    ifu_psel_i = 1'b1;
    ifu_paddr_i = 32'h8000_0000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t1_psel", mem_psel_o, 1'b1);
      check("t1_paddr", mem_paddr_o, 32'h8000_0000);
      check("t1_pwrite", mem_pwrite_o, 1'b0);
      check("t1_wait_rdy", ifu_pready_o, 1'b0);
      cyc();
    end
    mem_pready_i = 1'b1;
    mem_prdata_i = 32'h0000_0413;
    ifu_psel_i = 1'b0;
    @(negedge clock);
    check("t1_ifu_rdy", ifu_pready_o, 1'b1);
    check("t1_ifu_rdata", ifu_prdata_o, 32'h0000_0413);
    check("t1_lsu_rdy", lsu_pready_o, 1'b0);
    cyc();
    mem_pready_i = 1'b0;
    @(negedge clock);
    check("t1_idle", mem_psel_o, 1'b0);
    cyc();

    // LSU write against a zero-wait slave.
    lsu_psel_i = 1'b1;
    lsu_pwrite_i = 1'b1;
    lsu_paddr_i = 32'ha000_03f8;
    lsu_pwdata_i = 32'h41;
    lsu_pstrb_i = 4'h1;
    cyc();
    lsu_psel_i = 1'b0;
    mem_pready_i = 1'b1;
    mem_prdata_i = 32'hdead_beef;
    @(negedge clock);
    check("t2_psel", mem_psel_o, 1'b1);
    check("t2_pwrite", mem_pwrite_o, 1'b1);
    check("t2_pstrb", mem_pstrb_o, 4'h1);
    check("t2_paddr", mem_paddr_o, 32'ha000_03f8);
    check("t2_pwdata", mem_pwdata_o, 32'h41);
    check("t2_lsu_rdy", lsu_pready_o, 1'b1);
    check("t2_ifu_rdy", ifu_pready_o, 1'b0);
    cyc();
    mem_pready_i = 1'b0;
    lsu_pwrite_i = 1'b0;
    @(negedge clock);
    check("t2_idle", mem_psel_o, 1'b0);
    cyc();

`ifndef ARB_ROUND_ROBIN_EN
    // Simultaneous requests under fixed priority: LSU first, IFU two cycles after LSU completes.
    ifu_psel_i = 1'b1;
    ifu_paddr_i = 32'h8000_0100;
    lsu_psel_i = 1'b1;
    lsu_paddr_i = 32'h0000_3000;
    cyc();
    lsu_psel_i = 1'b0;
    mem_pready_i = 1'b1;
    @(negedge clock);
    check("t3_lsu_paddr", mem_paddr_o, 32'h0000_3000);
    check("t3_lsu_rdy", lsu_pready_o, 1'b1);
    check("t3_ifu_rdy", ifu_pready_o, 1'b0);
    cyc();
    mem_pready_i = 1'b0;
    @(negedge clock);
    check("t3_bubble", mem_psel_o, 1'b0);
    cyc();
    @(negedge clock);
    check("t3_ifu_psel", mem_psel_o, 1'b1);
    check("t3_ifu_paddr", mem_paddr_o, 32'h8000_0100);
    cyc();
    ifu_psel_i = 1'b0;
    mem_pready_i = 1'b1;
    @(negedge clock);
    check("t3_ifu_rdy", ifu_pready_o, 1'b1);
    cyc();
    mem_pready_i = 1'b0;
    cyc();
    check("t3_model_order", {grants[grants.size()-2], grants[grants.size()-1]}, 2'b10);
`else
    // Both masters held continuously: grants must alternate starting with the IFU.
    ifu_psel_i = 1'b1;
    ifu_paddr_i = 32'h0000_1000;
    lsu_psel_i = 1'b1;
    lsu_paddr_i = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      int budget = 0;
      cyc();
      while (!mem_psel_o && budget < 10) begin
        cyc();
        budget++;
      end
      if (!mem_psel_o) check("t4_timeout", 1'b0, 1'b1);
      seen.push_back(mem_paddr_o);
      mem_pready_i = 1'b1;
      if (t == 3) begin
        ifu_psel_i = 1'b0;
        lsu_psel_i = 1'b0;
      end
      cyc();
      mem_pready_i = 1'b0;
    end
    cyc();
    check("t4_g0", seen[0], 32'h0000_1000);
    check("t4_g1", seen[1], 32'h0000_2000);
    check("t4_g2", seen[2], 32'h0000_1000);
    check("t4_g3", seen[3], 32'h0000_2000);
    check("t4_model_order", {grants[grants.size()-4], grants[grants.size()-3],
                             grants[grants.size()-2], grants[grants.size()-1]}, 4'b0101);
`endif

    // IFU changes its address mid-grant and drops psel in the completion cycle.
    p0 = ifu_pulses;
    ifu_psel_i = 1'b1;
    ifu_paddr_i = 32'h8000_0000;
    cyc();
    ifu_paddr_i = 32'h8000_0004;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("t5_paddr_hold", mem_paddr_o, 32'h8000_0000);
      cyc();
    end
    ifu_psel_i = 1'b0;
    mem_pready_i = 1'b1;
    @(negedge clock);
    check("t5_paddr_done", mem_paddr_o, 32'h8000_0000);
    cyc();
    mem_pready_i = 1'b0;
    cyc();
    cyc();
    check("t5_one_pulse", ifu_pulses - p0, 1);

    // Reset during an LSU grant, then a stray slave completion while idle.
    lsu_psel_i = 1'b1;
    lsu_paddr_i = 32'h4000_0000;
    cyc();
    lsu_psel_i = 1'b0;
    cyc();
    check("t6_granted", mem_psel_o, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_psel_after_rst", mem_psel_o, 1'b0);
    mem_pready_i = 1'b1;
    @(negedge clock);
    check("t6_ifu_rdy", ifu_pready_o, 1'b0);
    check("t6_lsu_rdy", lsu_pready_o, 1'b0);
    check("t6_paddr_cleared", mem_paddr_o, 32'h0);
    cyc();
    mem_pready_i = 1'b0;
    cyc();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      ifu_psel_i   = $urandom_range(0, 1);
      lsu_psel_i   = $urandom_range(0, 1);
      ifu_paddr_i  = $urandom;
      lsu_paddr_i  = $urandom;
      lsu_pwrite_i = $urandom_range(0, 1);
      lsu_pwdata_i = $urandom;
      lsu_pstrb_i  = 4'($urandom);
      mem_pready_i = ($urandom_range(0, 9) < 4);
      mem_prdata_i = $urandom;
      cyc();
    end
    reset = 1'b0;
    ifu_psel_i = 1'b0;
    lsu_psel_i = 1'b0;
    mem_pready_i = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
